// File: rtl/sobel_window_3x3.sv
// rtl/sobel_window_3x3.sv - 3x3 Sobel |Gx|+|Gy| over three aligned line streams; SOBEL_THRESHOLD_EN selects binary output
module sobel_window_3x3 #(
  parameter int COLORDEPTH = 8,
  parameter int LATENCY    = 3
`ifdef SOBEL_THRESHOLD_EN
  ,
  parameter int THRESHOLD  = 128
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COLORDEPTH-1:0] row0_i,
  input  logic [COLORDEPTH-1:0] row1_i,
  input  logic [COLORDEPTH-1:0] row2_i,
  input  logic                  dv_i,
  input  logic                  hs_i,
  input  logic                  vs_i,
  output logic [COLORDEPTH-1:0] data_o,
  output logic                  dv_o,
  output logic                  hs_o,
  output logic                  vs_o
);

  // Four guard bits hold the signed 4*max swing of each gradient and the
  // unsigned sum of both magnitudes without overflow.
  localparam int W = COLORDEPTH + 4;
  localparam logic [W-1:0] PIX_MAX = {4'b0000, {COLORDEPTH{1'b1}}};
`ifdef SOBEL_THRESHOLD_EN
  localparam logic [W-1:0] THR = W'(THRESHOLD);
`endif

  // win[r][c]: r=0 newest line, c=2 newest column
  logic [COLORDEPTH-1:0] win [0:2][0:2];
  logic [1:0]            col_cnt;
  logic [1:0]            row_cnt;
  logic [LATENCY-1:0]    dv_dly;
  logic [LATENCY-1:0]    hs_dly;
  logic [LATENCY-1:0]    vs_dly;
  logic                  valid_win;
  logic                  tag1;
  logic                  tag2;
  logic signed [W-1:0]   gx;
  logic signed [W-1:0]   gy;
  logic [W-1:0]          abs_gx;
  logic [W-1:0]          abs_gy;
  logic [W-1:0]          mag;
  logic [COLORDEPTH-1:0] sat;
  logic [COLORDEPTH-1:0] pix_next;

  function automatic logic signed [W-1:0] ext(input logic [COLORDEPTH-1:0] x);
    return $signed({4'b0000, x});
  endfunction

  // A window is complete once three columns of the current run and two
  // earlier lines of the frame have been seen.
  assign valid_win = dv_i && (col_cnt == 2'd2) && (row_cnt == 2'd2);

  // Stage 1: shift the newest column in on every valid pixel, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (dv_i) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= row0_i;
      win[1][2] <= row1_i;
      win[2][2] <= row2_i;
    end
  end

  // Stage 1: border counters and the validity tag that rides with the window
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= 2'd0;
      row_cnt <= 2'd0;
      tag1    <= 1'b0;
    end else begin
      tag1 <= valid_win;
      if (!dv_i) begin
        col_cnt <= 2'd0;
      end else if (col_cnt < 2'd2) begin
        col_cnt <= col_cnt + 2'd1;
      end
      // Any dv gap counts as a line end; vsync wins over the increment
      if (vs_i) begin
        row_cnt <= 2'd0;
      end else if (dv_dly[0] && !dv_i && (row_cnt < 2'd2)) begin
        row_cnt <= row_cnt + 2'd1;
      end
    end
  end

  // Sync delay line: dv/hs/vs pass through untouched, LATENCY clocks late
  always_ff @(posedge clk) begin
    if (rst) begin
      dv_dly <= '0;
      hs_dly <= '0;
      vs_dly <= '0;
    end else begin
      dv_dly <= {dv_dly[LATENCY-2:0], dv_i};
      hs_dly <= {hs_dly[LATENCY-2:0], hs_i};
      vs_dly <= {vs_dly[LATENCY-2:0], vs_i};
    end
  end

  // Stage 2: signed horizontal and vertical gradients of the window
  always_ff @(posedge clk) begin
    if (rst) begin
      gx   <= '0;
      gy   <= '0;
      tag2 <= 1'b0;
    end else begin
      gx   <= (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]))
            - (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]));
      gy   <= (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
            - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));
      tag2 <= tag1;
    end
  end

  // Stage 3 combinational: magnitude, saturation, optional threshold, blanking
  always_comb begin
    abs_gx   = gx[W-1] ? $unsigned(-gx) : $unsigned(gx);
    abs_gy   = gy[W-1] ? $unsigned(-gy) : $unsigned(gy);
    mag      = abs_gx + abs_gy;
    sat      = (mag > PIX_MAX) ? {COLORDEPTH{1'b1}} : mag[COLORDEPTH-1:0];
`ifdef SOBEL_THRESHOLD_EN
    pix_next = ({4'b0000, sat} >= THR) ? {COLORDEPTH{1'b1}} : {COLORDEPTH{1'b0}};
`else
    pix_next = sat;
`endif
    if (!tag2 || !dv_dly[1]) begin
      pix_next = '0;
    end
  end

  // Stage 3: output pixel register
  always_ff @(posedge clk) begin
    if (rst) begin
      data_o <= '0;
    end else begin
      data_o <= pix_next;
    end
  end

  assign dv_o = dv_dly[LATENCY-1];
  assign hs_o = hs_dly[LATENCY-1];
  assign vs_o = vs_dly[LATENCY-1];

endmodule

// File: tb/tb_sobel_window_3x3.sv
// tb/tb_sobel_window_3x3.sv - directed table-driven bench for sobel_window_3x3
module tb_sobel_window_3x3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] row0_i, row1_i, row2_i;
  logic       dv_i, hs_i, vs_i;
  logic [7:0] data_o;
  logic       dv_o, hs_o, vs_o;

  always #5 clk = ~clk;

  sobel_window_3x3 #(.COLORDEPTH(8), .LATENCY(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .row0_i (row0_i),
    .row1_i (row1_i),
    .row2_i (row2_i),
    .dv_i   (dv_i),
    .hs_i   (hs_i),
    .vs_i   (vs_i),
    .data_o (data_o),
    .dv_o   (dv_o),
    .hs_o   (hs_o),
    .vs_o   (vs_o)
  );

  typedef struct {
    logic [7:0] d;
    logic       dv;
    logic       hs;
    logic       vs;
  } exp_t;

  // Line pattern: columns 0-7 take the left pixels, 8-15 the right pixels.
  // el/er: windows entirely left/right; s1/s2: newest column 8/9.
  typedef struct {
    logic [7:0] l0, l1, l2;
    logic [7:0] r0, r1, r2;
    logic [7:0] el, s1, s2, er;
  } vec_t;

  vec_t vt [6];
  exp_t exq [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  function automatic logic [7:0] thr_map(input logic [7:0] x);
`ifdef SOBEL_THRESHOLD_EN
    return (x >= 8'd128) ? 8'hff : 8'h00;
`else
    return x;
`endif
  endfunction

  function automatic logic [7:0] px(input int k, input int r, input int c);
    if (c < 8) return (r == 0) ? vt[k].l0 : (r == 1) ? vt[k].l1 : vt[k].l2;
    return (r == 0) ? vt[k].r0 : (r == 1) ? vt[k].r1 : vt[k].r2;
  endfunction

  function automatic logic [7:0] col_exp(input int k, input int c);
    logic [7:0] v;
    if (c < 8)       v = vt[k].el;
    else if (c == 8) v = vt[k].s1;
    else if (c == 9) v = vt[k].s2;
    else             v = vt[k].er;
    return thr_map(v);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // One clock: check outputs due now, then drive inputs and queue their expectation
  task automatic tick(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                      input logic dv, input logic hs, input logic vs, input logic rs,
                      input logic [7:0] ed);
    exp_t e;
    @(negedge clk);
    if (exq.size() >= 3) begin
      e = exq.pop_front();
      chk($sformatf("data_o@%0d", cyc), data_o, e.d);
      chk($sformatf("dv_o@%0d", cyc), {7'd0, dv_o}, {7'd0, e.dv});
      chk($sformatf("hs_o@%0d", cyc), {7'd0, hs_o}, {7'd0, e.hs});
      chk($sformatf("vs_o@%0d", cyc), {7'd0, vs_o}, {7'd0, e.vs});
    end
    rst    = rs;
    row0_i = a0;
    row1_i = a1;
    row2_i = a2;
    dv_i   = dv;
    hs_i   = hs;
    vs_i   = vs;
    if (rs) begin
      e.d = 8'h00; e.dv = 1'b0; e.hs = 1'b0; e.vs = 1'b0;
      foreach (exq[i]) exq[i] = e;
    end else begin
      e.d = ed; e.dv = dv; e.hs = hs; e.vs = vs;
    end
    exq.push_back(e);
    cyc++;
  endtask

  task automatic idle();
    tick(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
  endtask

  task automatic frame_start();
    tick(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0);
    idle();
  endtask

  // 16-pixel line with optional one-cycle dv gap before column gap_at,
  // followed by a two-cycle blanking interval carrying hsync
  task automatic line(input int k, input bit rows_ok, input int gap_at);
    int seg;
    seg = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == gap_at) begin
        idle();
        seg = 0;
      end
      tick(px(k, 0, c), px(k, 1, c), px(k, 2, c), 1'b1, 1'b0, 1'b0, 1'b0,
           (rows_ok && seg >= 2) ? col_exp(k, c) : 8'h00);
      seg++;
    end
    tick(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
  endtask

  initial begin
    bit rows_ok;
    int seg;

    rst = 1'b1; row0_i = '0; row1_i = '0; row2_i = '0;
    dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;

    //          l0   l1   l2   r0   r1   r2   el   s1   s2   er
    vt[0] = '{8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd0,  8'd0,   8'd0,   8'd0};
    vt[1] = '{8'd0,   8'd0,   8'd0,   8'd255, 8'd255, 8'd255, 8'd0,  8'd255, 8'd255, 8'd0};
    vt[2] = '{8'd20,  8'd20,  8'd0,   8'd20,  8'd20,  8'd0,   8'd80, 8'd80,  8'd80,  8'd80};
    vt[3] = '{8'd0,   8'd0,   8'd0,   8'd10,  8'd10,  8'd10,  8'd0,  8'd40,  8'd40,  8'd0};
    vt[4] = '{8'd10,  8'd20,  8'd30,  8'd50,  8'd50,  8'd50,  8'd80, 8'd180, 8'd140, 8'd0};
    vt[5] = '{8'd0,   8'd0,   8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0};

    // Reset: outputs must read zero
    repeat (4) tick(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

    // Uniform frame, 8 lines
    frame_start();
    for (int l = 0; l < 8; l++) line(0, l >= 2, -1);

    // Each pattern: vsync clears rows, two blanked lines, then two live lines
    for (int k = 1; k < 6; k++) begin
      frame_start();
      line(k, 1'b0, -1);
      line(k, 1'b0, -1);
      line(k, 1'b1, -1);
      line(k, 1'b1, -1);
    end

    // dv gap inside a live line restarts the column border
    line(4, 1'b1, 5);

    // Reset mid-line during valid output
    frame_start();
    line(1, 1'b0, -1);
    line(1, 1'b0, -1);
    rows_ok = 1'b1;
    seg = 0;
    for (int c = 0; c < 16; c++) begin
      if (c == 10) begin
        tick(px(1, 0, c), px(1, 1, c), px(1, 2, c), 1'b1, 1'b0, 1'b0, 1'b1, 8'd0);
        rows_ok = 1'b0;
        seg = 0;
      end else begin
        tick(px(1, 0, c), px(1, 1, c), px(1, 2, c), 1'b1, 1'b0, 1'b0, 1'b0,
             (rows_ok && seg >= 2) ? col_exp(1, c) : 8'h00);
        seg++;
      end
    end
    tick(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    tick(8'd0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    line(1, 1'b0, -1);
    line(1, 1'b1, -1);

    repeat (4) idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
